// File: rtl/seq_ripple_subtractor.sv
// seq_ripple_subtractor: multi-cycle ripple-borrow subtractor, diff = a - b - bin.
// Works on SLICE bits per clock, LSB slice first, with the borrow kept in a
// register between slices. Results and flags are published together on the
// single cycle that enters DONE and then held until the next completed operation.
module seq_ripple_subtractor #(
   parameter int WIDTH = 16,
   parameter int SLICE = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             zero,
   output logic             ovf
);

   localparam int N  = WIDTH / SLICE;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST_SLICE = CW'(N - 1);

   generate
      if (WIDTH < 2) begin : g_bad_width
         $error("seq_ripple_subtractor: WIDTH must be >= 2");
      end
      if ((SLICE < 1) || ((WIDTH % SLICE) != 0)) begin : g_bad_slice
         $error("seq_ripple_subtractor: WIDTH must be a multiple of SLICE");
      end
   endgenerate

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // One full-subtractor cell: returns {borrow_out, difference}.
   function automatic logic [1:0] full_sub(input logic x, input logic y, input logic bi);
      logic d;
      logic bo;
      d  = x ^ y ^ bi;
      bo = (~x & y) | (~(x ^ y) & bi);
      return {bo, d};
   endfunction

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             borrow_q, borrow_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             bout_q, bout_d;
   logic             zero_q, zero_d;
   logic             ovf_q, ovf_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [SLICE-1:0] a_slc_s;
   logic [SLICE-1:0] b_slc_s;
   logic [SLICE-1:0] d_slc_s;
   logic             msb_bin_s;   // borrow into the top bit of the current slice
   logic             slc_bout_s;  // borrow out of the current slice

   // Ripple chain over the current slice, fed by the stored borrow.
   always_comb begin
      logic       brw_s;
      logic [1:0] cell_s;
      a_slc_s   = a_q[int'(cnt_q) * SLICE +: SLICE];
      b_slc_s   = b_q[int'(cnt_q) * SLICE +: SLICE];
      d_slc_s   = '0;
      brw_s     = borrow_q;
      cell_s    = 2'b00;
      for (int i = 0; i < SLICE - 1; i++) begin
         cell_s     = full_sub(a_slc_s[i], b_slc_s[i], brw_s);
         d_slc_s[i] = cell_s[0];
         brw_s      = cell_s[1];
      end
      // Top cell handled separately so its borrow-in is visible for overflow.
      msb_bin_s          = brw_s;
      cell_s             = full_sub(a_slc_s[SLICE-1], b_slc_s[SLICE-1], brw_s);
      d_slc_s[SLICE-1]   = cell_s[0];
      slc_bout_s         = cell_s[1];
   end

   // Next-state, datapath and output-register update logic.
   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      borrow_d = borrow_q;
      cnt_d    = cnt_q;
      res_d    = res_q;
      diff_d   = diff_q;
      bout_d   = bout_q;
      zero_d   = zero_q;
      ovf_d    = ovf_q;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d  = ST_RUN;
               a_d      = a;
               b_d      = b;
               borrow_d = bin;
               cnt_d    = '0;
               res_d    = '0;
               busy_d   = 1'b1;
            end else begin
               state_d  = ST_IDLE;
            end
         end
         ST_RUN: begin
            res_d[int'(cnt_q) * SLICE +: SLICE] = d_slc_s;
            borrow_d = slc_bout_s;
            if (cnt_q == LAST_SLICE) begin
               // Final slice: publish result and flags together.
               state_d = ST_DONE;
               cnt_d   = '0;
               done_d  = 1'b1;
               diff_d  = res_d;
               bout_d  = slc_bout_s;
               zero_d  = (res_d == {WIDTH{1'b0}});
               ovf_d   = msb_bin_s ^ slc_bout_s;
            end else begin
               cnt_d   = cnt_q + 1'b1;
               busy_d  = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, datapath and output registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         borrow_q <= 1'b0;
         cnt_q    <= '0;
         res_q    <= '0;
         diff_q   <= '0;
         bout_q   <= 1'b0;
         zero_q   <= 1'b0;
         ovf_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         borrow_q <= borrow_d;
         cnt_q    <= cnt_d;
         res_q    <= res_d;
         diff_q   <= diff_d;
         bout_q   <= bout_d;
         zero_q   <= zero_d;
         ovf_q    <= ovf_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign diff = diff_q;
   assign bout = bout_q;
   assign zero = zero_q;
   assign ovf  = ovf_q;

endmodule
